// File: rtl/fx_reverb_comb.sv
// fx_reverb_comb: multi-channel feedback-comb reverb for FX slot 7.
//
// Each channel owns a DEPTH-word delay line in one shared single-port-style
// inferred RAM. A one-pole lowpass sits in the feedback path and a dry/wet
// mixer forms the output. One shared arithmetic path walks the channels in
// turn (RD, WAIT, DAMP, WR per channel) once per sample_en, then presents the
// whole frame on audio_out with a one-cycle out_valid strobe.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset; restarts the RAM clear
//   audio_in    per-channel signed input samples (channel c in [c])
//   sample_en   one-cycle strobe, new input frame present
//   fx_size     room size, sets delay length L
//   fx_damping  feedback lowpass strength, 0 = no damping
//   fx_mix      dry/wet mix, 0 = fully dry
//   audio_out   registered processed frame
//   out_valid   one-cycle pulse when audio_out updates
//   busy        high while clearing RAM or processing a frame
//   overrun     sticky flag, a sample_en arrived while a frame was in flight
module fx_reverb_comb #(
    parameter int DATA_W     = 16,
    parameter int PARAM_W    = 7,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 4096,
    parameter int SIZE_SHIFT = 5,
    parameter int FEEDBACK   = 107
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  audio_in,
    input  logic                           sample_en,
    input  logic [PARAM_W-1:0]             fx_size,
    input  logic [PARAM_W-1:0]             fx_damping,
    input  logic [PARAM_W-1:0]             fx_mix,
    output logic [NUM_CH-1:0][DATA_W-1:0]  audio_out,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int IW  = $clog2(DEPTH);
    localparam int AW  = $clog2(NUM_CH * DEPTH);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Signed working width; leaves headroom over DATA_W+PARAM_W+2.
    localparam int MW  = DATA_W + PARAM_W + 4;
    localparam int U   = 1 << PARAM_W;
    // Width that holds (fx_size+1)<<SIZE_SHIFT and DEPTH-1 without loss.
    localparam int LW0 = PARAM_W + 1 + SIZE_SHIFT;
    localparam int LW  = (LW0 > IW) ? LW0 : IW + 1;

    localparam logic [AW-1:0]         CLR_LAST = AW'(NUM_CH * DEPTH - 1);
    localparam logic [CHW-1:0]        CH_LAST  = CHW'(NUM_CH - 1);
    localparam logic signed [MW-1:0]  SAT_MAX  = MW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [MW-1:0]  SAT_MIN  = MW'(-(1 << (DATA_W - 1)));

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StRd,
        StWait,
        StDamp,
        StWr,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    logic [AW-1:0]                  r_clr;
    logic [CHW-1:0]                 r_ch;
    logic [IW-1:0]                  r_wptr;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_x;
    logic [PARAM_W-1:0]             r_size;
    logic [PARAM_W-1:0]             r_damp;
    logic [PARAM_W-1:0]             r_mix;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_lp;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_y;
    logic [DATA_W-1:0]              r_lp_new;
    logic [DATA_W-1:0]              r_rd_data;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_audio_out;
    logic                           r_out_valid;
    logic                           r_overrun;
    logic [DATA_W-1:0]              r_mem [NUM_CH * DEPTH];

    logic [LW-1:0]                  w_len_raw;
    logic [IW-1:0]                  w_len;
    logic [IW-1:0]                  w_rd_idx;
    logic [AW-1:0]                  w_ch_base;
    logic [AW-1:0]                  w_rd_addr;
    logic [AW-1:0]                  w_wr_addr;
    logic                           w_mem_we;
    logic [DATA_W-1:0]              w_mem_wdata;

    logic signed [MW-1:0]           w_x;
    logic signed [MW-1:0]           w_d;
    logic signed [MW-1:0]           w_lp;
    logic signed [MW-1:0]           w_lpn;
    logic signed [MW-1:0]           w_kd;
    logic signed [MW-1:0]           w_kmix;
    logic signed [MW-1:0]           w_mix;
    logic signed [MW-1:0]           w_damp_sum;
    logic signed [MW-1:0]           w_fb_sum;
    logic signed [MW-1:0]           w_mix_sum;

    function automatic logic [DATA_W-1:0] sat(input logic signed [MW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end
        return v[DATA_W-1:0];
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StClear;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StClear: if (r_clr == CLR_LAST) w_state_nxt = StIdle;
            StIdle:  if (sample_en) w_state_nxt = StRd;
            StRd:    w_state_nxt = StWait;
            StWait:  w_state_nxt = StDamp;
            StDamp:  w_state_nxt = StWr;
            StWr:    w_state_nxt = (r_ch == CH_LAST) ? StDone : StRd;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StClear;
        endcase
    end

    // ---------------- Addressing ----------------
    always_comb begin
        w_len_raw = (LW'(r_size) + LW'(1)) << SIZE_SHIFT;
        w_len     = (w_len_raw > LW'(DEPTH - 1)) ? IW'(DEPTH - 1) : w_len_raw[IW-1:0];
        // IW-bit subtraction gives the modulo-DEPTH wrap for free.
        w_rd_idx  = r_wptr - w_len;
        w_ch_base = AW'(r_ch) << IW;
        w_rd_addr = w_ch_base | AW'(w_rd_idx);
        w_wr_addr = (r_state == StClear) ? r_clr : (w_ch_base | AW'(r_wptr));
        w_mem_we  = (r_state == StClear) || (r_state == StWr);
    end

    // ---------------- Shared arithmetic path ----------------
    always_comb begin
        w_x    = MW'(signed'(r_x[r_ch]));
        w_d    = MW'(signed'(r_rd_data));
        w_lp   = MW'(signed'(r_lp[r_ch]));
        w_lpn  = MW'(signed'(r_lp_new));
        w_kd   = MW'(U) - MW'(r_damp);
        w_kmix = MW'(U) - MW'(r_mix);
        w_mix  = MW'(r_mix);

        w_damp_sum = w_lp + (((w_d - w_lp) * w_kd) >>> PARAM_W);
        w_fb_sum   = w_x + ((w_lpn * MW'(FEEDBACK)) >>> PARAM_W);
        w_mix_sum  = ((w_x * w_kmix) + (w_lpn * w_mix)) >>> PARAM_W;

        w_mem_wdata = (r_state == StClear) ? '0 : sat(w_fb_sum);
    end

    // ---------------- Delay-line RAM (no reset, inferred) ----------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_addr] <= w_mem_wdata;
        end
        if (r_state == StRd) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    // ---------------- Datapath / control registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr       <= '0;
            r_ch        <= '0;
            r_wptr      <= '0;
            r_x         <= '0;
            r_size      <= '0;
            r_damp      <= '0;
            r_mix       <= '0;
            r_lp        <= '0;
            r_y         <= '0;
            r_lp_new    <= '0;
            r_audio_out <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (sample_en && (r_state != StIdle) && (r_state != StClear)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                StClear: r_clr <= r_clr + AW'(1);
                StIdle: begin
                    if (sample_en) begin
                        r_x    <= audio_in;
                        r_size <= fx_size;
                        r_damp <= fx_damping;
                        r_mix  <= fx_mix;
                        r_ch   <= '0;
                    end
                end
                // lp_new always lies between lp and d, so sat() never clips here.
                StDamp: r_lp_new <= sat(w_damp_sum);
                StWr: begin
                    r_lp[r_ch] <= r_lp_new;
                    r_y[r_ch]  <= sat(w_mix_sum);
                    if (r_ch != CH_LAST) begin
                        r_ch <= r_ch + CHW'(1);
                    end
                end
                StDone: begin
                    r_audio_out <= r_y;
                    r_out_valid <= 1'b1;
                    r_wptr      <= r_wptr + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign audio_out = r_audio_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != StIdle);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_fx_reverb_comb.sv
// Testbench for fx_reverb_comb (default parameters, NUM_CH=2).
// Driver pushes hand-computed expected frames plus their due cycle into a
// queue; an independent monitor pops and compares on every out_valid.
module tb_fx_reverb_comb;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0][15:0]  audio_in;
    logic              sample_en = 1'b0;
    logic [6:0]        fx_size;
    logic [6:0]        fx_damping;
    logic [6:0]        fx_mix;
    logic [1:0][15:0]  audio_out;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];

    fx_reverb_comb dut (
        .clk        (clk),
        .reset      (reset),
        .audio_in   (audio_in),
        .sample_en  (sample_en),
        .fx_size    (fx_size),
        .fx_damping (fx_damping),
        .fx_mix     (fx_mix),
        .audio_out  (audio_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every out_valid must match the oldest expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got frame %h want no pulse", audio_out);
            end else begin
                e = q.pop_front();
                check("frame_data", audio_out, e.data);
                check("frame_latency", cyc, e.due);
            end
        end
    end

    // Called mid-cycle so the asynchronous clear is visible before any edge.
    task automatic apply_reset();
        int cnt;
        reset = 1'b1;
        #1;
        check("rst_audio_out", audio_out, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_overrun", overrun, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        while (busy && cnt < 20000) begin
            cnt++;
            sample_en = (cnt == 100);  // must be ignored during the clear
            @(negedge clk);
        end
        sample_en = 1'b0;
        check("clear_cycles", cnt, 8192);
        check("clear_overrun", overrun, 1'b0);
        check("clear_audio_out", audio_out, 32'h0);
    endtask

    task automatic send(input logic [15:0] x1, input logic [15:0] x0, input logic [6:0] sz,
                        input logic [6:0] dmp, input logic [6:0] mx,
                        input logic [15:0] e1, input logic [15:0] e0);
        @(negedge clk);
        audio_in   = {x1, x0};
        fx_size    = sz;
        fx_damping = dmp;
        fx_mix     = mx;
        sample_en  = 1'b1;
        q.push_back('{data: {e1, e0}, due: cyc + 10});
        @(negedge clk);
        sample_en = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Impulse through L=32, no damping, almost fully wet.
    task automatic run_impulse();
        logic [15:0] e0;
        for (int f = 0; f < 65; f++) begin
            e0 = (f == 0) ? 16'h0080 : (f == 32) ? 16'h3F80 : (f == 64) ? 16'h3515 : 16'h0000;
            send(16'h0000, (f == 0) ? 16'h4000 : 16'h0000, 7'd0, 7'd0, 7'd127, 16'h0000, e0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        audio_in   = '0;
        fx_size    = '0;
        fx_damping = '0;
        fx_mix     = '0;

        // Power-on reset and full RAM clear.
        repeat (2) @(negedge clk);
        #2;
        apply_reset();

        // Fully dry passes input through unchanged, including extremes.
        send(16'h1234, 16'hEDCC, 7'd0, 7'd0, 7'd0, 16'h1234, 16'hEDCC);
        send(16'h7FFF, 16'h8000, 7'd127, 7'd127, 7'd0, 16'h7FFF, 16'h8000);

        // Back-to-back sample_en: second is dropped; mid-frame control change ignored.
        @(negedge clk);
        audio_in  = {16'h0AAA, 16'hF555};
        fx_mix    = 7'd0;
        sample_en = 1'b1;
        q.push_back('{data: {16'h0AAA, 16'hF555}, due: cyc + 10});
        @(negedge clk);
        audio_in = {16'h1111, 16'h2222};
        fx_mix   = 7'd127;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (10) @(negedge clk);
        check("overrun_set", overrun, 1'b1);
        send(16'h0102, 16'hFEFE, 7'd0, 7'd0, 7'd0, 16'h0102, 16'hFEFE);
        check("overrun_sticky", overrun, 1'b1);

        // Impulse response.
        @(negedge clk);
        #2;
        apply_reset();
        run_impulse();

        // Abort a frame during ch1 DAMP, then the impulse must replay identically.
        @(negedge clk);
        audio_in  = {16'h1000, 16'h2000};
        fx_mix    = 7'd64;
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        apply_reset();
        run_impulse();

        // Positive saturation.
        @(negedge clk);
        #2;
        apply_reset();
        for (int f = 0; f < 200; f++) begin
            send(16'h7FFF, 16'h7FFF, 7'd0, 7'd0, 7'd127,
                 (f < 32) ? 16'h00FF : 16'h7FFF, (f < 32) ? 16'h00FF : 16'h7FFF);
        end

        // Negative saturation.
        @(negedge clk);
        #2;
        apply_reset();
        for (int f = 0; f < 200; f++) begin
            send(16'h8000, 16'h8000, 7'd0, 7'd0, 7'd127,
                 (f < 32) ? 16'hFF00 : 16'h8000, (f < 32) ? 16'hFF00 : 16'h8000);
        end

        repeat (5) @(negedge clk);
        check("frames_outstanding", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fx_reverb_comb.md
Name: fx_reverb_comb

Overview:
Parametrised multi-channel feedback-comb reverb that replaces the pass-through reverb in FX slot 7. Each channel has its own delay line in a shared inferred RAM, with a one-pole damping lowpass in the feedback path and a dry/wet mixer. Channels are processed one after another through a single shared arithmetic path, once per sample_en, and results are presented as a registered frame with an out_valid strobe.

Parameters:
DATA_W, 16, signed sample width (two's complement)
PARAM_W, 7, width of the fx_size/fx_damping/fx_mix controls; unity scale is U = 2^PARAM_W
NUM_CH, 2, number of audio channels
DEPTH, 4096, delay-line words per channel; must be a power of 2
SIZE_SHIFT, 5, delay-length scale per fx_size step
FEEDBACK, 107, comb feedback gain, unsigned Q0.PARAM_W (107/128 ≈ 0.84); must be < U

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
audio_in  in  NUM_CH x DATA_W  per-channel input samples
sample_en  in  1  one-cycle strobe: new input frame is present
fx_size  in  PARAM_W  room size; sets the delay length
fx_damping  in  PARAM_W  high-frequency damping; 0 means no damping
fx_mix  in  PARAM_W  dry/wet mix; 0 means fully dry
audio_out  out  NUM_CH x DATA_W  processed output frame, registered
out_valid  out  1  one-cycle pulse when audio_out updates
busy  out  1  high while clearing memory or processing a frame
overrun  out  1  sticky; set when a sample_en is dropped while processing

Behaviour:
- Reset (asynchronous, active-high) drives, immediately:
  - audio_out=0, out_valid=0, overrun=0, busy=1.
  - Lowpass states lp[ch]=0, write pointer wptr=0, FSM=CLEAR, channel index ch=0.
- CLEAR:
  - Writes 0 to every one of NUM_CH*DEPTH RAM words, one per cycle. The address is {ch, idx}.
  - Lasts exactly NUM_CH*DEPTH cycles, then goes to IDLE with busy=0.
  - sample_en during CLEAR is ignored and does not set overrun.
- IDLE, on sample_en=1:
  - Latch audio_in, fx_size, fx_damping and fx_mix for the whole frame.
  - Set ch=0, busy=1, go to RD.
- Per-channel states (4 cycles per channel):
  - RD: issue the read address {ch, (wptr - L) mod DEPTH}.
  - WAIT: RAM data d arrives (1-cycle read latency).
  - DAMP: lp_new = lp[ch] + (((d - lp[ch]) * (U - fx_damping)) >>> PARAM_W).
  - WR:
    - Write w = sat(x + ((lp_new * FEEDBACK) >>> PARAM_W)) to {ch, wptr}.
    - Store lp[ch] = lp_new.
    - Store y[ch] = sat((x*(U - fx_mix) + lp_new*fx_mix) >>> PARAM_W).
    - Then ch++ and go to RD, or go to DONE after the last channel.
- DONE (1 cycle):
  - audio_out <= y, out_valid=1 for this cycle only.
  - wptr <= (wptr+1) mod DEPTH, busy=0, back to IDLE.
- Latency: sample_en sampled at edge k gives audio_out/out_valid at edge k + 4*NUM_CH + 1 (edge k+9 for NUM_CH=2).
- Delay length: L = min(DEPTH-1, (fx_size+1) << SIZE_SHIFT).
  - fx_size=0 gives L=32; fx_size=127 gives 4095.
- Arithmetic rules:
  - All arithmetic is signed, with intermediates wide enough that nothing overflows (at least DATA_W+PARAM_W+2 bits).
  - >>> is an arithmetic (floor) shift.
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Boundary cases:
  - fx_mix=0 makes audio_out bit-exact equal to audio_in.
  - fx_damping=0 makes lp_new = d exactly.
  - Read/write addresses wrap modulo DEPTH.
- sample_en while busy in any non-IDLE, non-CLEAR state: the request is dropped and overrun is set to 1. overrun stays 1 until reset.
- Changing a control input mid-frame has no effect until the next frame.
- Reset mid-frame aborts the frame: no out_valid is issued, and CLEAR restarts from address 0.

Test Plan:
1. Reset pulse, then release -> busy=1 for exactly NUM_CH*DEPTH=8192 cycles, all outputs 0, then busy=0; every RAM word reads 0.
2. fx_mix=0, audio_in={16'h1234, 16'hEDCC}, one sample_en -> out_valid exactly 9 cycles later, audio_out={16'h1234, 16'hEDCC}.
3. Impulse on ch0 with fx_size=0, fx_damping=0, fx_mix=127: 16'h4000 then zeros, one sample_en per frame -> ch0 output:
   - 16'h0080 at frame 0;
   - 0 for frames 1–31;
   - 16'h3F80 at frame 32;
   - 16'h3515 at frame 64;
   - ch1 output 0 throughout.
4. Constant 16'h7FFF input with fx_mix=127 over 200 frames -> RAM writes and audio_out never exceed 16'h7FFF and never wrap negative. Repeat with 16'h8000 -> clamps at 16'h8000.
5. sample_en on two consecutive cycles -> exactly one out_valid, overrun=1 and stays 1; the next frame still processes normally.
6. Assert reset during DAMP of ch1 -> audio_out=0 and out_valid=0 immediately, no pulse follows, busy=1, CLEAR restarts; the test 3 impulse then replays identically.
